// File: rtl/gray_fifo_read_ctrl_if.sv
// Read-side FIFO pointer bus: the write-pointer input from the write domain,
// the pop handshake, and the read-address/status outputs.
interface gray_fifo_read_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 4
);
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0]      WrPtrGray_in;
  logic                  ReadReq_in;
  logic                  ReadAck_out;
  logic [ADDR_WIDTH-1:0] RdAddr_out;
  logic [PTR_W-1:0]      RdPtrGray_out;
  logic                  Empty_out;
  logic [PTR_W-1:0]      Level_out;
  logic                  Underflow_out;

  modport master (
    output WrPtrGray_in,
    output ReadReq_in,
    input  ReadAck_out,
    input  RdAddr_out,
    input  RdPtrGray_out,
    input  Empty_out,
    input  Level_out,
    input  Underflow_out
  );

  modport slave (
    input  WrPtrGray_in,
    input  ReadReq_in,
    output ReadAck_out,
    output RdAddr_out,
    output RdPtrGray_out,
    output Empty_out,
    output Level_out,
    output Underflow_out
  );
endinterface

// File: rtl/gray_fifo_read_ctrl.sv
// Read-side pointer controller for a dual-clock FIFO: synchronizes the Gray
// write pointer, tracks the read pointer, and produces Empty/Level/Underflow.
module gray_fifo_read_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  Rst_n_in,
  gray_fifo_read_ctrl_if.slave  bus
);
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] r_sync [SYNC_STAGES];
  logic [PTR_W-1:0] r_rd_bin;
  logic [PTR_W-1:0] r_rd_gray;
  logic             r_empty;
  logic [PTR_W-1:0] r_level;
  logic             r_underflow;

  logic [PTR_W-1:0] w_wq_gray;
  logic [PTR_W-1:0] w_wq_bin;
  logic             w_ack;
  logic [PTR_W-1:0] w_rd_bin_next;
  logic [PTR_W-1:0] w_rd_gray_next;

  // Write-pointer synchronizer chain; the last stage is the usable copy.
  always_ff @(posedge Clk or negedge Rst_n_in) begin
    if (!Rst_n_in) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= bus.WrPtrGray_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_wq_gray = r_sync[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_wq_bin = '0;
    for (int i = 0; i < int'(PTR_W); i++) begin
      w_wq_bin[i] = ^(w_wq_gray >> i);
    end
  end

  assign w_ack          = bus.ReadReq_in & ~r_empty;
  assign w_rd_bin_next  = r_rd_bin + PTR_W'(w_ack);
  assign w_rd_gray_next = w_rd_bin_next ^ (w_rd_bin_next >> 1);

  always_ff @(posedge Clk or negedge Rst_n_in) begin
    if (!Rst_n_in) begin
      r_rd_bin    <= '0;
      r_rd_gray   <= '0;
      r_empty     <= 1'b1;
      r_level     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_rd_bin    <= w_rd_bin_next;
      r_rd_gray   <= w_rd_gray_next;
      r_empty     <= (w_rd_gray_next == w_wq_gray);
      // Modular difference stays correct across pointer wrap.
      r_level     <= w_wq_bin - w_rd_bin_next;
      r_underflow <= bus.ReadReq_in & r_empty;
    end
  end

  assign bus.ReadAck_out   = w_ack;
  assign bus.RdAddr_out    = r_rd_bin[ADDR_WIDTH-1:0];
  assign bus.RdPtrGray_out = r_rd_gray;
  assign bus.Empty_out     = r_empty;
  assign bus.Level_out     = r_level;
  assign bus.Underflow_out = r_underflow;

endmodule

// File: tb/tb_gray_fifo_read_ctrl.sv
// Directed bench for gray_fifo_read_ctrl (ADDR_WIDTH=4, SYNC_STAGES=2).
module tb_gray_fifo_read_ctrl;
  localparam int unsigned ADDR_WIDTH = 4;

  logic Clk;
  logic Rst_n_in;
  logic clk_en;
  int   n_checks;
  int   n_pass;

  gray_fifo_read_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  gray_fifo_read_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .SYNC_STAGES(2)) dut (
    .Clk      (Clk),
    .Rst_n_in (Rst_n_in),
    .bus      (bus)
  );

  always begin
    #5;
    if (clk_en) Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_idle_reset(input string tag);
    check({tag, "_empty"}, 32'(bus.Empty_out), 32'd1);
    check({tag, "_level"}, 32'(bus.Level_out), 32'd0);
    check({tag, "_addr"},  32'(bus.RdAddr_out), 32'd0);
    check({tag, "_gray"},  32'(bus.RdPtrGray_out), 32'd0);
    check({tag, "_ack"},   32'(bus.ReadAck_out), 32'd0);
    check({tag, "_uflow"}, 32'(bus.Underflow_out), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    Clk      = 1'b0;
    clk_en   = 1'b0;
    Rst_n_in = 1'b1;
    bus.WrPtrGray_in = '0;
    bus.ReadReq_in   = 1'b0;

    // Reset with the clock stopped.
    #2 Rst_n_in = 1'b0;
    #1 check_idle_reset("rst");
    #2 Rst_n_in = 1'b1;
    #2 clk_en = 1'b1;
    tick();

    // First write: visible on the third edge after it is presented.
    bus.WrPtrGray_in = 5'b00001;
    tick();
    check("w1_e0_empty", 32'(bus.Empty_out), 32'd1);
    tick();
    check("w1_e1_empty", 32'(bus.Empty_out), 32'd1);
    tick();
    check("w1_e2_empty", 32'(bus.Empty_out), 32'd0);
    check("w1_e2_level", 32'(bus.Level_out), 32'd1);
    bus.ReadReq_in = 1'b1;
    #1 check("w1_ack", 32'(bus.ReadAck_out), 32'd1);
    tick();
    bus.ReadReq_in = 1'b0;
    check("w1_pop_addr",  32'(bus.RdAddr_out), 32'd1);
    check("w1_pop_gray",  32'(bus.RdPtrGray_out), 32'b00001);
    check("w1_pop_empty", 32'(bus.Empty_out), 32'd1);
    check("w1_pop_level", 32'(bus.Level_out), 32'd0);

    // Restart both sides, then fill to 16 and drain.
    Rst_n_in = 1'b0;
    bus.WrPtrGray_in = '0;
    #1 check_idle_reset("rst2");
    Rst_n_in = 1'b1;
    tick();
    bus.WrPtrGray_in = 5'b11000;
    tick(); tick(); tick();
    check("full_level", 32'(bus.Level_out), 32'd16);
    check("full_empty", 32'(bus.Empty_out), 32'd0);
    bus.ReadReq_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("drain_ack%0d", i),   32'(bus.ReadAck_out), 32'd1);
      check($sformatf("drain_addr%0d", i),  32'(bus.RdAddr_out), 32'(i));
      check($sformatf("drain_level%0d", i), 32'(bus.Level_out), 32'(16 - i));
      tick();
    end
    check("drain_end_addr",  32'(bus.RdAddr_out), 32'd0);
    check("drain_end_level", 32'(bus.Level_out), 32'd0);
    check("drain_end_empty", 32'(bus.Empty_out), 32'd1);
    check("drain_end_ack",   32'(bus.ReadAck_out), 32'd0);
    check("drain_end_uflow", 32'(bus.Underflow_out), 32'd0);

    // Underflow: request held while empty.
    tick();
    check("uflow_pulse", 32'(bus.Underflow_out), 32'd1);
    check("uflow_addr",  32'(bus.RdAddr_out), 32'd0);
    bus.ReadReq_in = 1'b0;
    tick();
    check("uflow_clear", 32'(bus.Underflow_out), 32'd0);

    // Wrap: writer steps 17..32 (one Gray bit per step), read pointer at 16.
    for (int b = 17; b <= 32; b++) begin
      bus.WrPtrGray_in = gray5(5'(b));
      tick();
    end
    tick(); tick(); tick();
    check("wrap_fill_level", 32'(bus.Level_out), 32'd16);
    bus.ReadReq_in = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    bus.ReadReq_in = 1'b0;
    check("wrap_rd30_addr",  32'(bus.RdAddr_out), 32'd14);
    check("wrap_rd30_level", 32'(bus.Level_out), 32'd2);
    bus.WrPtrGray_in = 5'b00001;
    tick(); tick(); tick();
    check("wrap_w33_level", 32'(bus.Level_out), 32'd3);
    check("wrap_w33_empty", 32'(bus.Empty_out), 32'd0);
    bus.ReadReq_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("wrap_ack%0d", i), 32'(bus.ReadAck_out), 32'd1);
      tick();
    end
    bus.ReadReq_in = 1'b0;
    check("wrap_end_addr",  32'(bus.RdAddr_out), 32'd1);
    check("wrap_end_gray",  32'(bus.RdPtrGray_out), 32'b00001);
    check("wrap_end_empty", 32'(bus.Empty_out), 32'd1);
    check("wrap_end_level", 32'(bus.Level_out), 32'd0);

    // Reset mid-drain with five entries outstanding.
    for (int b = 2; b <= 6; b++) begin
      bus.WrPtrGray_in = gray5(5'(b));
      tick();
    end
    tick(); tick(); tick();
    check("mid_level5", 32'(bus.Level_out), 32'd5);
    Rst_n_in = 1'b0;
    bus.WrPtrGray_in = '0;
    #1 check_idle_reset("mid_rst");
    #1 Rst_n_in = 1'b1;
    tick();
    bus.WrPtrGray_in = 5'b00011;
    tick(); tick(); tick();
    check("resume_level", 32'(bus.Level_out), 32'd2);
    bus.ReadReq_in = 1'b1;
    #1;
    check("resume_ack",   32'(bus.ReadAck_out), 32'd1);
    check("resume_addr0", 32'(bus.RdAddr_out), 32'd0);
    tick();
    bus.ReadReq_in = 1'b0;
    check("resume_addr1", 32'(bus.RdAddr_out), 32'd1);
    check("resume_level1", 32'(bus.Level_out), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
